serial_subtractor: RTL and testbench

Multi-cycle unsigned/two's-complement subtractor computing `diff = a - b - bin` one DIGIT-wide slice per clock, LSB slice first, with an internal borrow flip-flop. It is the inverse-direction companion to the team's ripple-carry adder datapath. It trades latency for a single DIGIT-wide borrow chain, and sits behind a start/done handshake so a controller can issue operations back-to-back.

---
 rtl/serial_subtractor.sv | 73 +++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, one DIGIT-wide slice per clock, LSB slice first
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nx;
  logic [DIGIT:0] s;
  logic borrow, borrow_n, a_msb, b_msb, last;
  // slice subtract, result shift-in and final-slice detect
  always_comb begin
    s = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]} - (DIGIT+1)'(borrow);
    borrow_n = s[DIGIT];
    r_nx = WIDTH'({s[DIGIT-1:0], r_sr} >> DIGIT);
    last = cnt == CW'(N - 1);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: accept start only when idle, leave RUN after the last slice
  always_comb state_n = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  // outputs decoded from state
  always_comb busy = state == RUN;
  // datapath: capture operands, process slices, publish result on the final slice
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      borrow <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= state == RUN && last;
      if (state == IDLE) begin
        if (start) begin
          a_sr <= a;
          b_sr <= b;
          borrow <= bin;
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
          cnt <= '0;
        end
      end else begin
        a_sr <= a_sr >> DIGIT;
        b_sr <= b_sr >> DIGIT;
        r_sr <= r_nx;
        borrow <= borrow_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          diff <= r_nx;
          bout <= borrow_n;
          ovf <= (a_msb != b_msb) && (r_nx[WIDTH-1] != a_msb);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, handshake sequences and random regression against an arithmetic model
module tb_serial_subtractor;
  logic clk = 0, rst = 1, rst_x = 1, start = 0, bin = 0;
  logic [15:0] a = 0, b = 0, diff;
  logic busy, done, bout, ovf;
  logic st8 = 0, bin8 = 0, busy8, done8, bout8, ovf8, f8 = 0;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic st12 = 0, bin12 = 0, busy12, done12, bout12, ovf12, f12 = 0;
  logic [11:0] a12 = 0, b12 = 0, diff12;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf));
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst_x), .start(st8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));
  serial_subtractor #(.WIDTH(12), .DIGIT(12)) dut12 (.clk(clk), .rst(rst_x), .start(st12), .a(a12), .b(b12), .bin(bin12),
    .busy(busy12), .done(done12), .diff(diff12), .bout(bout12), .ovf(ovf12));

  typedef struct {
    logic [15:0] a, b;
    logic bin;
    logic [15:0] diff;
    logic bout, ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] f = {1'b0, x} - {1'b0, y} - 17'(bi);
    return {(x[15] != y[15]) && (f[15] != x[15]), f};
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic bi, input logic noise, input string name);
    logic [17:0] e = model(x, y, bi);
    start = 1; a = x; b = y; bin = bi;
    tick();
    start = 0;
    check({name, "_busy0"}, busy, 1);
    for (int i = 1; i <= 4; i++) begin
      if (noise) begin
        start = 1'($urandom); a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      end
      tick();
      check({name, "_done"}, done, i == 4);
      check({name, "_busy"}, busy, i != 4);
    end
    start = 0;
    check({name, "_res"}, {ovf, bout, diff}, e);
  endtask

  initial begin
    vec_t vt[7];
    vt[0] = '{16'h1234, 16'h0234, 0, 16'h1000, 0, 0};
    vt[1] = '{16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0};
    vt[2] = '{16'h0005, 16'h0005, 1, 16'hFFFF, 1, 0};
    vt[3] = '{16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1};
    vt[4] = '{16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1};
    vt[5] = '{16'hFFFF, 16'h0000, 1, 16'hFFFE, 0, 0};
    vt[6] = '{16'h0000, 16'hFFFF, 1, 16'h0000, 1, 0};
    tick(); tick();
    check("rst_outs", {busy, done, ovf, bout, diff}, 0);
    rst = 0; rst_x = 0;
    tick();
    check("idle_busy", busy, 0);
    for (int i = 0; i < 7; i++) begin
      start = 1; a = vt[i].a; b = vt[i].b; bin = vt[i].bin;
      tick();
      start = 0;
      for (int c = 1; c <= 4; c++) begin
        check("vec_busy", busy, 1);
        tick();
      end
      check("vec_done", done, 1);
      check("vec_diff", diff, vt[i].diff);
      check("vec_bout", bout, vt[i].bout);
      check("vec_ovf", ovf, vt[i].ovf);
      tick();
      check("vec_pulse", done, 0);
      check("vec_hold", diff, vt[i].diff);
    end
    // ignored start mid-run, then back-to-back start in the done cycle
    start = 1; a = 16'h00FF; b = 16'h000F; bin = 0;
    tick();
    start = 0;
    tick();
    start = 1; a = 16'hAAAA; b = 16'h5555;
    tick();
    start = 0;
    tick(); tick();
    check("hs_done1", done, 1);
    check("hs_diff1", diff, 16'h00F0);
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c <= 4; c++) begin
      check("hs_gap_done", done, 0);
      check("hs_gap_hold", diff, 16'h00F0);
      tick();
    end
    check("hs_done2", done, 1);
    check("hs_res2", {ovf, bout, diff}, {1'b1, 1'b0, 16'h5555});
    tick();
    // reset mid-operation
    start = 1; a = 16'h1234; b = 16'h0001;
    tick();
    start = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("mrst_outs", {busy, done, ovf, bout, diff}, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("mrst_nodone", done, 0);
    end
    run_op(16'h0010, 16'h0001, 0, 0, "fresh");
    check("fresh_diff", diff, 16'h000F);
    tick();
    for (int k = 0; k < 10000; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rnd");
      if ($urandom_range(0, 7) == 0) tick();
    end
    for (int i = 0; i < 100000 && !(f8 && f12); i++) tick();
    check("narrow_finished", {f8, f12}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [8:0] e8;
    int n;
    wait (rst_x == 0);
    tick();
    for (int k = 0; k < 2000; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      e8 = {1'b0, a8} - {1'b0, b8} - 9'(bin8);
      st8 = 1;
      tick();
      st8 = 0;
      n = 0;
      while (!done8 && n < 10) begin
        tick();
        n++;
      end
      check("w8_lat", n, 4);
      check("w8_res", {ovf8, bout8, diff8}, {(a8[7] != b8[7]) && (e8[7] != a8[7]), e8});
    end
    f8 = 1;
  end

  initial begin
    logic [12:0] e12;
    int n;
    wait (rst_x == 0);
    tick();
    for (int k = 0; k < 2000; k++) begin
      a12 = 12'($urandom); b12 = 12'($urandom); bin12 = 1'($urandom);
      e12 = {1'b0, a12} - {1'b0, b12} - 13'(bin12);
      st12 = 1;
      tick();
      st12 = 0;
      n = 0;
      while (!done12 && n < 10) begin
        tick();
        n++;
      end
      check("w12_lat", n, 1);
      check("w12_res", {ovf12, bout12, diff12}, {(a12[11] != b12[11]) && (e12[11] != a12[11]), e12});
    end
    f12 = 1;
  end
endmodule
